switch_code_reader: RTL and testbench
=====================================

SWITCH_CODE_READER -- requirements
Module: switch_code_reader

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 16, meaning the number of consecutive stable clocks required to accept a pattern; legal range 2..65535.
REQ-002 SHALL have parameter CNT_W, default 16, meaning the debounce counter width; DEBOUNCE_CYCLES-1 must fit in CNT_W bits.
REQ-003 SHALL have port clk, input, 1 bit: the single clock.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous to clk and active-high.
REQ-005 SHALL have ports sw_0, sw_1 and sw_2, each input, 1 bit: raw asynchronous switch lines, lamp-position order matching led_0..led_2.
REQ-006 SHALL have port code_out, output, 3 bits: the decoded value.
REQ-007 SHALL have port code_valid, output, 1 bit: code_out is valid.
REQ-008 SHALL have port code_ready, input, 1 bit: the consumer accepts code_out.
REQ-009 SHALL have port code_err, output, 1 bit: one-cycle pulse on an undecodable pattern.

Function
REQ-010 SHALL pass each sw_x line through a 2-flop synchronizer. Synchronized pattern P = {sw_2, sw_1, sw_0}.
REQ-011 SHALL decode P to code_out as follows:
- 001 -> 000
- 010 -> 001
- 011 -> 010
- 100 -> 011
- 101 -> 100
- 111 -> 101
- 000 -> no event
- 110 -> error
REQ-012 SHALL implement FSM states IDLE, SETTLE, HOLD and RELEASE.
REQ-013 In IDLE, when P != 000: SHALL latch P into cap, clear cnt and enter SETTLE.
REQ-014 In SETTLE, when P == cap: cnt SHALL increment; on reaching DEBOUNCE_CYCLES-1, the FSM SHALL decode cap.
REQ-015 In SETTLE, when P != cap and P != 000: SHALL re-latch cap = P, clear cnt and stay in SETTLE.
REQ-016 In SETTLE, when P == 000: SHALL return to IDLE with no output.
REQ-017 On a valid decode, SHALL register code_out and enter HOLD; code_valid SHALL be high from the next cycle.
REQ-018 On a decode of 110, SHALL pulse code_err for exactly one cycle, assert no code_valid, and enter RELEASE.
REQ-019 In HOLD, SHALL hold code_valid high and code_out stable until code_valid & code_ready; changes on P SHALL be ignored.
REQ-020 On the handshake cycle, SHALL enter RELEASE; code_valid SHALL be low the following cycle.
REQ-021 code_ready asserted outside HOLD SHALL have no effect.
REQ-022 In RELEASE, SHALL require P == 000 for DEBOUNCE_CYCLES consecutive clocks before entering IDLE; any nonzero P SHALL clear cnt.
REQ-023 Latency: SHALL assert code_valid exactly DEBOUNCE_CYCLES+3 clocks after a clean raw pattern change, measured from the first sampling edge.
REQ-024 Counter: SHALL saturate, never wrap; cnt SHALL be cleared on every state entry.
REQ-025 A switch release during HOLD SHALL NOT drop code_valid; the released level SHALL count toward RELEASE debounce only after the handshake.

Reset
REQ-026 While rst is high at a clk edge, SHALL set: state = IDLE, cnt = 0, cap = 000, code_out = 000, code_valid = 0, code_err = 0, synchronizer flops = 0.
REQ-027 Reset mid-operation, in any state, SHALL drop code_valid and code_err the next cycle with no handshake completed.
REQ-028 After reset release, a switch already held SHALL be treated as a fresh press: full debounce, then decode.

Structure
REQ-029 A shared package SHALL hold:
- the FSM state enum;
- the 3-bit pattern constants (PAT_NONE, PAT_ERR);
- the code constants matching the LED mapping, shared with the LED driver.
REQ-030 The synchronizer SHALL be a separate sub-module, sync_2ff, parameterized by width and instantiated once with width 3.
REQ-031 Target size is 120-400 lines of RTL; no combinational path from code_ready to code_valid in the same cycle.

Verification (DEBOUNCE_CYCLES=4)
REQ-032 Raw 011 held; code_ready=1 -> code_valid high at cycle 7, code_out=010, one-cycle valid; release to 000 for 4 clocks -> back in IDLE.
REQ-033 Raw 001 for 2 clocks, then 100 held -> single code_valid with code_out=011; no code_out=000 ever emitted.
REQ-034 Raw 110 held -> code_err high for exactly 1 cycle, code_valid never high; after release 000 for 4 clocks, raw 101 -> code_out=100.
REQ-035 Raw 111 with code_ready=0 for 20 cycles, raw changed to 000 meanwhile -> code_valid and code_out=101 stable throughout; ready=1 -> valid drops the next cycle.
REQ-036 Bouncing release (000/010 toggling every clock, 10 clocks) -> no new event; then 000 stable for 4 clocks -> IDLE.
REQ-037 rst pulsed while in HOLD -> code_valid=0 the next cycle; switch still at 010 -> a new valid with code_out=001 after the full latency.

Source files
------------

// File: rtl/switch_code_reader_pkg.sv
// Shared types and constants for the switch code reader and the LED driver.
package switch_code_reader_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    HOLD    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam int unsigned PAT_W  = 3;
  localparam int unsigned CODE_W = 3;

  localparam logic [PAT_W-1:0] PAT_NONE = 3'b000;
  localparam logic [PAT_W-1:0] PAT_ERR  = 3'b110;

  // Code values follow LED position order so the LED driver can reuse them.
  localparam logic [CODE_W-1:0] CODE_0 = 3'd0;
  localparam logic [CODE_W-1:0] CODE_1 = 3'd1;
  localparam logic [CODE_W-1:0] CODE_2 = 3'd2;
  localparam logic [CODE_W-1:0] CODE_3 = 3'd3;
  localparam logic [CODE_W-1:0] CODE_4 = 3'd4;
  localparam logic [CODE_W-1:0] CODE_5 = 3'd5;

  function automatic logic [CODE_W-1:0] decode_pat(input logic [PAT_W-1:0] pat);
    logic [CODE_W-1:0] code;
    code = CODE_0;
    case (pat)
      3'b001:  code = CODE_0;
      3'b010:  code = CODE_1;
      3'b011:  code = CODE_2;
      3'b100:  code = CODE_3;
      3'b101:  code = CODE_4;
      3'b111:  code = CODE_5;
      default: code = CODE_0;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/switch_code_reader_sync_2ff.sv
// Two-flop synchronizer for asynchronous input lines, synchronous active-high reset.
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/switch_code_reader.sv
// Debounces a 3-line switch pattern, decodes it to a 3-bit code and offers it via valid/ready.
module switch_code_reader
  import switch_code_reader_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned CNT_W           = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sw_0,
  input  logic              sw_1,
  input  logic              sw_2,
  output logic [CODE_W-1:0] code_out,
  output logic              code_valid,
  input  logic              code_ready,
  output logic              code_err
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [PAT_W-1:0]  pat;
  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PAT_W-1:0]  cap_q, cap_d;
  logic [CODE_W-1:0] code_out_d;
  logic              code_valid_d;
  logic              code_err_d;

  sync_2ff #(.WIDTH(PAT_W)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   ({sw_2, sw_1, sw_0}),
    .q   (pat)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      cap_q      <= PAT_NONE;
      code_out   <= CODE_0;
      code_valid <= 1'b0;
      code_err   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cap_q      <= cap_d;
      code_out   <= code_out_d;
      code_valid <= code_valid_d;
      code_err   <= code_err_d;
    end
  end

  // Next-state and output logic; every state entry clears the counter.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    cap_d        = cap_q;
    code_out_d   = code_out;
    code_valid_d = 1'b0;
    code_err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (pat != PAT_NONE) begin
          cap_d   = pat;
          cnt_d   = '0;
          state_d = SETTLE;
        end
      end

      SETTLE: begin
        if (pat == PAT_NONE) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (pat != cap_q) begin
          cap_d = pat;
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (cap_q == PAT_ERR) begin
            code_err_d = 1'b1;
            state_d    = RELEASE;
          end else begin
            code_out_d = decode_pat(cap_q);
            state_d    = HOLD;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      // Switch activity is ignored here; only the handshake moves on.
      HOLD: begin
        if (code_valid && code_ready) begin
          cnt_d   = '0;
          state_d = RELEASE;
        end else begin
          code_valid_d = 1'b1;
        end
      end

      RELEASE: begin
        if (pat != PAT_NONE) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_switch_code_reader.sv
// Directed bench for switch_code_reader with DEBOUNCE_CYCLES=4.
module tb_switch_code_reader;
  import switch_code_reader_pkg::*;

  localparam int unsigned DEB = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       sw_0, sw_1, sw_2;
  logic [2:0] code_out;
  logic       code_valid;
  logic       code_ready;
  logic       code_err;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [2:0] raw;
    logic [2:0] code;
    logic       valid;
    logic       err;
  } vec_t;

  vec_t vecs[8];

  switch_code_reader #(.DEBOUNCE_CYCLES(DEB), .CNT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .sw_0       (sw_0),
    .sw_1       (sw_1),
    .sw_2       (sw_2),
    .code_out   (code_out),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .code_err   (code_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_raw(input logic [2:0] p);
    {sw_2, sw_1, sw_0} = p;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int state_i();
    return int'(dut.state_q);
  endfunction

  task automatic release_to_idle();
    set_raw(3'b000);
    for (int i = 0; i < 10; i++) tick();
    check("back_to_idle", state_i(), int'(IDLE));
  endtask

  // Apply one table vector with ready held high and observe 16 edges.
  task automatic run_vec(input vec_t v, input int idx);
    int first_valid, first_err, n_valid, n_err;
    logic [2:0] seen_code;
    first_valid = -1; first_err = -1; n_valid = 0; n_err = 0; seen_code = 3'b000;
    code_ready = 1'b1;
    set_raw(v.raw);
    for (int cyc = 0; cyc < 16; cyc++) begin
      tick();
      if (code_valid) begin
        if (first_valid < 0) begin
          first_valid = cyc;
          seen_code   = code_out;
        end
        n_valid++;
      end
      if (code_err) begin
        if (first_err < 0) first_err = cyc;
        n_err++;
      end
    end
    if (v.valid) begin
      check($sformatf("vec%0d_latency", idx), first_valid, int'(DEB) + 3);
      check($sformatf("vec%0d_code", idx), int'(seen_code), int'(v.code));
      check($sformatf("vec%0d_valid_cycles", idx), n_valid, 1);
      check($sformatf("vec%0d_err_cycles", idx), n_err, 0);
    end else if (v.err) begin
      check($sformatf("vec%0d_err_latency", idx), first_err, int'(DEB) + 2);
      check($sformatf("vec%0d_err_cycles", idx), n_err, 1);
      check($sformatf("vec%0d_valid_cycles", idx), n_valid, 0);
    end else begin
      check($sformatf("vec%0d_valid_cycles", idx), n_valid, 0);
      check($sformatf("vec%0d_err_cycles", idx), n_err, 0);
    end
    release_to_idle();
  endtask

  initial begin
    int first_valid, n_valid, n_bad, n_evt;

    vecs[0] = '{raw: 3'b011, code: 3'b010, valid: 1'b1, err: 1'b0};
    vecs[1] = '{raw: 3'b110, code: 3'b000, valid: 1'b0, err: 1'b1};
    vecs[2] = '{raw: 3'b101, code: 3'b100, valid: 1'b1, err: 1'b0};
    vecs[3] = '{raw: 3'b001, code: 3'b000, valid: 1'b1, err: 1'b0};
    vecs[4] = '{raw: 3'b010, code: 3'b001, valid: 1'b1, err: 1'b0};
    vecs[5] = '{raw: 3'b100, code: 3'b011, valid: 1'b1, err: 1'b0};
    vecs[6] = '{raw: 3'b111, code: 3'b101, valid: 1'b1, err: 1'b0};
    vecs[7] = '{raw: 3'b000, code: 3'b000, valid: 1'b0, err: 1'b0};

    rst = 1'b1;
    code_ready = 1'b0;
    set_raw(3'b101);
    for (int i = 0; i < 3; i++) tick();
    check("rst_code_out", int'(code_out), 0);
    check("rst_code_valid", int'(code_valid), 0);
    check("rst_code_err", int'(code_err), 0);
    check("rst_state", state_i(), int'(IDLE));
    set_raw(3'b000);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) tick();

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Short 001 glitch followed by a held 100: only the 100 may be reported.
    code_ready = 1'b1;
    first_valid = -1; n_valid = 0; n_bad = 0;
    set_raw(3'b001);
    tick(); tick();
    set_raw(3'b100);
    for (int cyc = 2; cyc < 22; cyc++) begin
      tick();
      if (code_valid) begin
        if (first_valid < 0) first_valid = cyc;
        n_valid++;
        if (code_out != 3'b011) n_bad++;
      end
    end
    check("relatch_latency", first_valid, int'(DEB) + 5);
    check("relatch_valid_cycles", n_valid, 1);
    check("relatch_wrong_code", n_bad, 0);
    release_to_idle();

    // Consumer stalls while the switch is released; output must stay put.
    code_ready = 1'b0;
    first_valid = -1; n_bad = 0;
    set_raw(3'b111);
    for (int cyc = 0; cyc < 30; cyc++) begin
      tick();
      if (code_valid && first_valid < 0) first_valid = cyc;
      if (cyc >= int'(DEB) + 3 && (!code_valid || code_out != 3'b101)) n_bad++;
      if (cyc == 10) set_raw(3'b000);
    end
    check("stall_latency", first_valid, int'(DEB) + 3);
    check("stall_unstable_cycles", n_bad, 0);
    code_ready = 1'b1;
    tick();
    check("stall_valid_after_handshake", int'(code_valid), 0);

    // Bouncing release: 010/000 alternation must keep RELEASE from finishing.
    n_evt = 0;
    for (int i = 0; i < 10; i++) begin
      set_raw((i % 2 == 0) ? 3'b010 : 3'b000);
      tick();
      if (code_valid || code_err) n_evt++;
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      if (code_valid || code_err) n_evt++;
    end
    check("bounce_events", n_evt, 0);
    check("bounce_still_release", state_i(), int'(RELEASE));
    tick();
    check("bounce_then_idle", state_i(), int'(IDLE));

    // Reset during HOLD, switch kept pressed: fresh full-latency decode.
    code_ready = 1'b0;
    first_valid = -1;
    set_raw(3'b010);
    for (int cyc = 0; cyc < 10; cyc++) tick();
    check("pre_reset_valid", int'(code_valid), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("reset_drops_valid", int'(code_valid), 0);
    check("reset_drops_err", int'(code_err), 0);
    for (int cyc = 1; cyc < 14; cyc++) begin
      tick();
      if (code_valid && first_valid < 0) begin
        first_valid = cyc;
        check("post_reset_code", int'(code_out), 1);
      end
    end
    check("post_reset_latency", first_valid, int'(DEB) + 4);
    code_ready = 1'b1;
    tick();
    check("post_reset_handshake", int'(code_valid), 0);
    release_to_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
